// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between instruction fetch and data access.
// Each access holds the port for WAIT_CYCLES cycles, then pulses the owner's done for one cycle.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;
  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  logic [1:0]        state_r;
  logic              ptr_r;    // 1: data side wins a tie
  logic              owner_r;  // 1: data side owns the port
  logic              we_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [3:0]        cnt_r;
  logic              mem_en_r;
  logic              mem_we_r;
  logic              if_done_r;
  logic              d_done_r;
  logic              busy_r;
  logic [DATA_W-1:0] if_rdata_r;
  logic [DATA_W-1:0] d_rdata_r;
  logic              grant_s;
  logic              grant_d_s;

  // Grant decision, only meaningful while idle
  always_comb begin
    grant_s   = 1'b0;
    grant_d_s = 1'b0;
    if (state_r == IDLE) begin
      if (d_req && if_req) begin
        grant_s   = 1'b1;
        grant_d_s = ptr_r;
      end else if (d_req) begin
        grant_s   = 1'b1;
        grant_d_s = 1'b1;
      end else if (if_req) begin
        grant_s   = 1'b1;
        grant_d_s = 1'b0;
      end else begin
        grant_s   = 1'b0;
        grant_d_s = 1'b0;
      end
    end else begin
      grant_s   = 1'b0;
      grant_d_s = 1'b0;
    end
  end

  // Access FSM with latched request, wait counter and read capture
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      ptr_r      <= 1'b1;
      owner_r    <= 1'b0;
      we_r       <= 1'b0;
      addr_r     <= '0;
      wdata_r    <= '0;
      cnt_r      <= 4'd0;
      mem_en_r   <= 1'b0;
      mem_we_r   <= 1'b0;
      if_done_r  <= 1'b0;
      d_done_r   <= 1'b0;
      busy_r     <= 1'b0;
      if_rdata_r <= '0;
      d_rdata_r  <= '0;
    end else begin
      if_done_r <= 1'b0;
      d_done_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (grant_s) begin
            owner_r  <= grant_d_s;
            ptr_r    <= ~grant_d_s;
            addr_r   <= grant_d_s ? d_addr : if_addr;
            we_r     <= grant_d_s & d_we;
            mem_we_r <= grant_d_s & d_we;
            if (grant_d_s) begin
              wdata_r <= d_wdata;
            end
            cnt_r    <= CNT_LOAD;
            mem_en_r <= 1'b1;
            busy_r   <= 1'b1;
            state_r  <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt_r == 4'd0) begin
            mem_en_r <= 1'b0;
            mem_we_r <= 1'b0;
            if (!we_r) begin
              if (owner_r) begin
                d_rdata_r <= mem_rdata;
              end else begin
                if_rdata_r <= mem_rdata;
              end
            end
            if (owner_r) begin
              d_done_r <= 1'b1;
            end else begin
              if_done_r <= 1'b1;
            end
            state_r <= RESP;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        RESP: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          mem_en_r <= 1'b0;
          mem_we_r <= 1'b0;
          busy_r   <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

  assign if_rdata  = if_rdata_r;
  assign if_done   = if_done_r;
  assign d_rdata   = d_rdata_r;
  assign d_done    = d_done_r;
  assign mem_en    = mem_en_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;
  assign busy      = busy_r;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-ported unified memory between the instruction-fetch path (PC side) and the data-memory path (load/store side) of the MIPS core. Each requester uses a level req / one-cycle done handshake. A three-state FSM owns the memory port for a configurable number of wait cycles per access, then returns the registered read data. The block sits between the pc/instruction-fetch and dataMem users and a shared memory model. Its busy output lets the top level stall the PC.

Parameters:
ADDR_W, 32, address width of all ports.
DATA_W, 32, data width of all ports.
WAIT_CYCLES, 2, cycles mem_en is held per access; legal range 1..15.

Ports:
clock  in  1  system clock; all state updates on the rising edge.
reset_n  in  1  asynchronous, active-low reset.
if_req  in  1  fetch request (level); fetch is read-only.
if_addr  in  ADDR_W  fetch address.
if_rdata  out  DATA_W  registered fetch read data.
if_done  out  1  one-cycle pulse: fetch access complete.
d_req  in  1  data request (level).
d_we  in  1  data access is a write when 1.
d_addr  in  ADDR_W  data address.
d_wdata  in  DATA_W  data write value.
d_rdata  out  DATA_W  registered load data.
d_done  out  1  one-cycle pulse: data access complete.
mem_en  out  1  memory access strobe.
mem_we  out  1  memory write strobe.
mem_addr  out  ADDR_W  memory address.
mem_wdata  out  DATA_W  memory write data.
mem_rdata  in  DATA_W  memory read data, valid while mem_en=1.
busy  out  1  high whenever state != IDLE.

Behaviour:
- States: IDLE, ACCESS, RESP. Requests are sampled only in IDLE.
- Reset (asynchronous, reset_n=0):
  - state=IDLE; all outputs 0, including if_rdata and d_rdata.
  - Priority pointer points to data.
  - Latched address, data, owner and wait counter cleared.
- IDLE:
  - No request pending: remain in IDLE.
  - Exactly one requester: grant it.
  - Both requesting: grant the requester named by the priority pointer.
  - After every grant, the pointer flips to the other requester (round-robin). Starvation of either side is therefore impossible.
  - On grant: latch owner, address, we (forced 0 for fetch), and wdata. Load counter with WAIT_CYCLES-1. Next state is ACCESS.
- ACCESS:
  - mem_en=1 every cycle; mem_addr, mem_we and mem_wdata come from the latches and are stable for the whole access.
  - Counter decrements each edge.
  - At the edge where counter==0 and the access is a read: capture mem_rdata into the owner's rdata register; next state RESP.
  - Writes leave d_rdata unchanged.
- RESP:
  - Owner's done=1 for exactly one cycle; mem_en=0.
  - Next state IDLE unconditionally.
  - Requests are ignored in RESP, so a requester that still holds req in its done cycle is not double-served. It must drop req by the following edge unless it wants another access.
- Latency and throughput:
  - Grant at edge k. mem_en is high for cycles k..k+WAIT_CYCLES-1. done is high in cycle k+WAIT_CYCLES.
  - Maximum throughput is one access per WAIT_CYCLES+2 cycles.
- Outside ACCESS, mem_en=0, mem_we=0, and mem_addr/mem_wdata hold their last value.
- Accesses are non-abortable. If req drops during ACCESS, the access still completes and done still pulses. Address or data changes on the requester's inputs after the grant are ignored.
- rdata registers hold their value until the next completed read by the same owner.
- Reset asserted mid-access: immediate abort. mem_en and mem_we drop asynchronously, no done is produced, and the pointer returns to data.
- The counter never wraps: the WAIT_CYCLES=1 edge case gives counter=0 on the first ACCESS cycle.

Test Plan:
- Fetch read (WAIT_CYCLES=2): reset, if_req=1, if_addr=0x00400000, mem returns 0x20020004 → mem_en high 2 cycles with mem_addr=0x00400000 and mem_we=0; if_done pulses 1 cycle at grant+2; if_rdata=0x20020004; d_done stays 0.
- Simultaneous first request: after reset, if_req=d_req=1 in the same cycle → data granted first; fetch granted on the next IDLE; d_done precedes if_done by 4 cycles.
- Data write: d_req=1, d_we=1, d_addr=0x10010000, d_wdata=0xDEADBEEF → mem_we and mem_en high 2 cycles with mem_wdata=0xDEADBEEF; d_done pulses once; d_rdata keeps its prior value.
- Sustained contention: both reqs held high for 16 cycles → grants alternate D, I, D, I; a done pulse every 4 cycles; busy low for exactly 1 cycle between accesses.
- Request withdrawal: d_req dropped one cycle after grant → access completes; d_done still pulses; no second grant follows.
- Reset mid-access: reset_n=0 during the first ACCESS cycle of a fetch → mem_en and busy go 0 immediately; no if_done. After release with both reqs high, data is granted first.
